// File: rtl/register_file_sb_pkg.sv
// Shared CPU register-file package.
// Holds the default register geometry and the register-index type used by
// decode, issue and writeback, plus a helper that gives how many registers
// can actually be marked busy (register 0 is excluded when hardwired to 0).
package register_file_sb_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;

    // Number of registers that can hold a busy bit.
    function automatic int unsigned rf_alloc_limit(input int addr_w, input bit zero_reg);
        return (32'd1 << addr_w) - (zero_reg ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Register-file bus: writeback port, issue (alloc) port, packed read ports
// and scoreboard status.
//   master : issue/decode/writeback side (drives indices, strobes, data)
//   slave  : the register file (returns operands, busy flags, count, full)
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_READ   = 2
);
    logic                           write_en;
    logic [ADDR_WIDTH-1:0]          write_reg;
    logic [DATA_WIDTH-1:0]          write_data;
    logic                           alloc_en;
    logic [ADDR_WIDTH-1:0]          alloc_reg;
    logic [NUM_READ*ADDR_WIDTH-1:0] read_reg;
    logic [NUM_READ*DATA_WIDTH-1:0] read_data;
    logic [NUM_READ-1:0]            read_busy;
    logic [ADDR_WIDTH:0]            busy_count;
    logic                           full;

    modport master (
        output write_en, write_reg, write_data, alloc_en, alloc_reg, read_reg,
        input  read_data, read_busy, busy_count, full
    );

    modport slave (
        input  write_en, write_reg, write_data, alloc_en, alloc_reg, read_reg,
        output read_data, read_busy, busy_count, full
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// rf_scoreboard: per-register busy vector with alloc-over-write priority,
// a registered count of busy registers and the full flag.
//   clk, reset          : clock, async active-low reset
//   alloc_en/alloc_reg  : issue marks a register busy
//   write_en/write_reg  : writeback clears the busy bit
//   busy                : busy vector, one bit per register
//   busy_count, full    : number of busy registers, all allocatable busy
module rf_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alloc_en,
    input  logic [ADDR_WIDTH-1:0]   alloc_reg,
    input  logic                    write_en,
    input  logic [ADDR_WIDTH-1:0]   write_reg,
    output logic [(1<<ADDR_WIDTH)-1:0] busy,
    output logic [ADDR_WIDTH:0]     busy_count,
    output logic                    full
);
    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam int          CW    = ADDR_WIDTH + 1;
    localparam int unsigned LIMIT = rf_alloc_limit(ADDR_WIDTH, ZERO_REG != 0);

    logic          set_v, clr_v, inc, dec;
    logic [CW-1:0] count_next;

    // Register 0 never tracks a producer when it is hardwired to zero.
    assign set_v = alloc_en && !((ZERO_REG != 0) && (alloc_reg == '0));
    assign clr_v = write_en && !((ZERO_REG != 0) && (write_reg == '0));

    // Count only real transitions: re-alloc of a busy register and writes
    // to idle registers are no-ops; alloc+write to the same register keeps
    // it busy, so the write must not decrement.
    always_comb begin
        inc        = set_v && !busy[alloc_reg];
        dec        = clr_v && busy[write_reg] && !(set_v && (alloc_reg == write_reg));
        count_next = busy_count + {{ADDR_WIDTH{1'b0}}, inc} - {{ADDR_WIDTH{1'b0}}, dec};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (clr_v) busy[write_reg] <= 1'b0;
            // Set after clear: the newer producer wins on a shared index.
            if (set_v) busy[alloc_reg] <= 1'b1;
            busy_count <= count_next;
        end
    end

    assign full = (busy_count == CW'(LIMIT));

    logic unused_depth;
    assign unused_depth = (DEPTH == 0);

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: multi-read, single-write register file with same-cycle
// write-to-read bypass, optional hardwired-zero register 0 and a per-register
// busy scoreboard so decode can stall on read_busy directly.
//   clk    : clock, all state updates on rising edge
//   reset  : async active-low, clears storage, busy bits and busy_count
//   bus    : register_file_sb_if slave (write, alloc, read ports, status)
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic          clk,
    input  logic          reset,
    register_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [DEPTH-1:0]                 busy;
    logic                             wr_ok;

    assign wr_ok = bus.write_en && !((ZERO_REG != 0) && (bus.write_reg == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
        end else if (wr_ok) begin
            mem[bus.write_reg] <= bus.write_data;
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (bus.alloc_en),
        .alloc_reg  (bus.alloc_reg),
        .write_en   (bus.write_en),
        .write_reg  (bus.write_reg),
        .busy       (busy),
        .busy_count (bus.busy_count),
        .full       (bus.full)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] r;
        logic                  is_zero;
        logic                  fwd;
        logic [DATA_WIDTH-1:0] val;

        assign r       = bus.read_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign is_zero = (ZERO_REG != 0) && (r == '0);
        // Forwarding is gated by reset so read_data stays 0 while reset is
        // held, even if writeback keeps strobing.
        assign fwd     = (BYPASS != 0) && reset && wr_ok && (bus.write_reg == r);

        always_comb begin
            val = mem[r];
            if (is_zero)  val = '0;
            else if (fwd) val = bus.write_data;
        end

        assign bus.read_data[i*DATA_WIDTH +: DATA_WIDTH] = val;
        // A forwarded write is the result the consumer was waiting for.
        assign bus.read_busy[i] = busy[r] && !is_zero && !fwd;
    end

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    localparam int K_RD   = 0;
    localparam int K_RB   = 1;
    localparam int K_CNT  = 2;
    localparam int K_FULL = 3;
    localparam int K_NRD  = 4;
    localparam int K_NRB  = 5;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();
    register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_nb ();

    // Same stimulus into a BYPASS=0 build.
    assign bus_nb.write_en   = bus.write_en;
    assign bus_nb.write_reg  = bus.write_reg;
    assign bus_nb.write_data = bus.write_data;
    assign bus_nb.alloc_en   = bus.alloc_en;
    assign bus_nb.alloc_reg  = bus.alloc_reg;
    assign bus_nb.read_reg   = bus.read_reg;

    register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
                       .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));

    register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
                       .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .reset(reset), .bus(bus_nb.slave));

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [31:0] sample(input int kind, input int port);
        case (kind)
            K_RD:    return bus.read_data[port*DW +: DW];
            K_RB:    return {31'b0, bus.read_busy[port]};
            K_CNT:   return {26'b0, bus.busy_count};
            K_FULL:  return {31'b0, bus.full};
            K_NRD:   return bus_nb.read_data[port*DW +: DW];
            K_NRB:   return {31'b0, bus_nb.read_busy[port]};
            default: return 32'hxxxxxxxx;
        endcase
    endfunction

    // Monitor: every falling edge, drain all expectations posted this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() != 0) begin
            e   = q.pop_front();
            act = sample(e.kind, e.port);
            n_chk++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
    end

    task automatic chk(input string name, input int kind, input int port, input logic [31:0] v);
        exp_t e;
        e.name = name; e.kind = kind; e.port = port; e.exp = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input logic ae, input logic [AW-1:0] ar,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        bus.write_en   = we;
        bus.write_reg  = wr;
        bus.write_data = wd;
        bus.alloc_en   = ae;
        bus.alloc_reg  = ar;
        bus.read_reg   = {r1, r0};
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
    endtask

    initial begin
        reset = 1'b0;
        idle(5'd1, 5'd2);

        // Reset held with strobes toggling: everything reads as zero.
        tick(); drive(1'b1, 5'd1, 32'hDEADBEEF, 1'b1, 5'd1, 5'd1, 5'd2);
        chk("rst_rd0", K_RD, 0, 32'h0);  chk("rst_rd1", K_RD, 1, 32'h0);
        chk("rst_rb0", K_RB, 0, 32'h0);  chk("rst_cnt", K_CNT, 0, 32'd0);
        chk("rst_full", K_FULL, 0, 32'd0); chk("rst_nrd0", K_NRD, 0, 32'h0);
        tick(); drive(1'b1, 5'd2, 32'h55, 1'b1, 5'd2, 5'd1, 5'd2);
        chk("rst_rd1_b", K_RD, 1, 32'h0); chk("rst_cnt_b", K_CNT, 0, 32'd0);
        tick(); reset = 1'b1; idle(5'd1, 5'd2);
        chk("rel_cnt", K_CNT, 0, 32'd0);

        // Write r1 then read it.
        tick(); drive(1'b1, 5'd1, 32'hAAAAAAAA, 1'b0, 5'd0, 5'd1, 5'd2);
        chk("r1_byp", K_RD, 0, 32'hAAAAAAAA); chk("r1_nb_old", K_NRD, 0, 32'h0);
        tick(); idle(5'd1, 5'd2);
        chk("r1_next", K_RD, 0, 32'hAAAAAAAA); chk("r1_nb_next", K_NRD, 0, 32'hAAAAAAAA);

        // Same-cycle bypass on port 1.
        tick(); drive(1'b1, 5'd2, 32'hCCCCCCCC, 1'b0, 5'd0, 5'd1, 5'd2);
        chk("r2_byp", K_RD, 1, 32'hCCCCCCCC); chk("r2_nb_old", K_NRD, 1, 32'h0);
        tick(); idle(5'd1, 5'd2);
        chk("r2_nb_next", K_NRD, 1, 32'hCCCCCCCC); chk("r2_next", K_RD, 1, 32'hCCCCCCCC);

        // Register 0 ignores write and alloc.
        tick(); drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd2);
        chk("r0_rd", K_RD, 0, 32'h0); chk("r0_rb", K_RB, 0, 32'h0);
        chk("r0_cnt", K_CNT, 0, 32'd0); chk("r0_nrd", K_NRD, 0, 32'h0);
        tick(); idle(5'd0, 5'd2);
        chk("r0_rd_after", K_RD, 0, 32'h0); chk("r0_rb_after", K_RB, 0, 32'h0);
        chk("r0_cnt_after", K_CNT, 0, 32'd0); chk("r0_nrd_after", K_NRD, 0, 32'h0);

        // Alloc r5, then writeback r5.
        tick(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd2);
        chk("r5_alloc_rb_now", K_RB, 0, 32'h0); chk("r5_alloc_cnt_now", K_CNT, 0, 32'd0);
        tick(); idle(5'd5, 5'd2);
        chk("r5_rb", K_RB, 0, 32'h1); chk("r5_cnt", K_CNT, 0, 32'd1); chk("r5_nrb", K_NRB, 0, 32'h1);
        tick(); drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd2);
        chk("r5_wb_rd", K_RD, 0, 32'h12345678); chk("r5_wb_rb", K_RB, 0, 32'h0);
        chk("r5_wb_nrb", K_NRB, 0, 32'h1); chk("r5_wb_nrd", K_NRD, 0, 32'h0);
        chk("r5_wb_cnt", K_CNT, 0, 32'd1);
        tick(); idle(5'd5, 5'd2);
        chk("r5_cnt_clr", K_CNT, 0, 32'd0); chk("r5_rb_clr", K_RB, 0, 32'h0);
        chk("r5_nrb_clr", K_NRB, 0, 32'h0); chk("r5_nrd_new", K_NRD, 0, 32'h12345678);

        // Alloc and write r7 in the same cycle.
        tick(); drive(1'b1, 5'd7, 32'h77777777, 1'b1, 5'd7, 5'd5, 5'd7);
        chk("r7_rd_now", K_RD, 1, 32'h77777777); chk("r7_rb_now", K_RB, 1, 32'h0);
        chk("r7_cnt_now", K_CNT, 0, 32'd0);
        tick(); idle(5'd5, 5'd7);
        chk("r7_rd", K_RD, 1, 32'h77777777); chk("r7_rb", K_RB, 1, 32'h1);
        chk("r7_cnt", K_CNT, 0, 32'd1); chk("r7_nrd", K_NRD, 1, 32'h77777777);

        // Alloc r3 while writing busy r4: net count unchanged.
        tick(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd3);
        chk("r4_alloc_cnt", K_CNT, 0, 32'd1);
        tick(); idle(5'd4, 5'd3);
        chk("r4_cnt", K_CNT, 0, 32'd2); chk("r4_rb", K_RB, 0, 32'h1);
        tick(); drive(1'b1, 5'd4, 32'h44444444, 1'b1, 5'd3, 5'd4, 5'd3);
        chk("r3r4_cnt_now", K_CNT, 0, 32'd2); chk("r4_rb_byp", K_RB, 0, 32'h0);
        chk("r3_rb_now", K_RB, 1, 32'h0); chk("r4_nrb_now", K_NRB, 0, 32'h1);
        tick(); idle(5'd4, 5'd3);
        chk("r3r4_cnt", K_CNT, 0, 32'd2); chk("r4_rb_clr", K_RB, 0, 32'h0);
        chk("r3_rb_set", K_RB, 1, 32'h1); chk("r4_rd", K_RD, 0, 32'h44444444);

        // Fill every non-zero register.
        for (int i = 1; i < 32; i++) begin
            tick(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'd9, 5'd31);
            if (i == 31) begin
                chk("fill_cnt30", K_CNT, 0, 32'd30); chk("fill_notfull", K_FULL, 0, 32'd0);
            end
        end
        tick(); idle(5'd9, 5'd31);
        chk("full_cnt", K_CNT, 0, 32'd31); chk("full_flag", K_FULL, 0, 32'd1);
        chk("full_rb9", K_RB, 0, 32'h1); chk("full_rb31", K_RB, 1, 32'h1);
        chk("full_nrb31", K_NRB, 1, 32'h1);

        // Re-alloc while full is idempotent.
        tick(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd31);
        chk("realloc_cnt_now", K_CNT, 0, 32'd31); chk("realloc_full_now", K_FULL, 0, 32'd1);
        tick(); idle(5'd9, 5'd31);
        chk("realloc_cnt", K_CNT, 0, 32'd31); chk("realloc_full", K_FULL, 0, 32'd1);

        // Writeback r9 drops out of full.
        tick(); drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd31);
        chk("wb9_cnt_now", K_CNT, 0, 32'd31); chk("wb9_rb", K_RB, 0, 32'h0);
        chk("wb9_rd", K_RD, 0, 32'h99);
        tick(); idle(5'd9, 5'd31);
        chk("wb9_cnt", K_CNT, 0, 32'd30); chk("wb9_full", K_FULL, 0, 32'd0);
        tick(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd10);
        chk("re9_cnt_now", K_CNT, 0, 32'd30);

        // Reset mid-cycle with write r10 and alloc r9 in flight.
        tick(); drive(1'b1, 5'd10, 32'hA0A0A0A0, 1'b1, 5'd9, 5'd9, 5'd10);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_cnt", K_CNT, 0, 32'd0); chk("mid_rst_full", K_FULL, 0, 32'd0);
        chk("mid_rst_rd1", K_RD, 1, 32'h0);  chk("mid_rst_rb0", K_RB, 0, 32'h0);
        chk("mid_rst_rb1", K_RB, 1, 32'h0);  chk("mid_rst_nrd1", K_NRD, 1, 32'h0);
        tick();
        chk("rst_hold_cnt", K_CNT, 0, 32'd0); chk("rst_hold_rd0", K_RD, 0, 32'h0);
        tick(); reset = 1'b1; idle(5'd9, 5'd10);
        chk("rel2_cnt", K_CNT, 0, 32'd0);
        tick(); idle(5'd9, 5'd10);
        chk("post_rd10", K_RD, 1, 32'h0); chk("post_nrd10", K_NRD, 1, 32'h0);
        chk("post_rb9", K_RB, 0, 32'h0);  chk("post_cnt", K_CNT, 0, 32'd0);

        tick(); tick();
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the CPU register file: a multi-read-port, single-write-port register file with write-to-read bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard. Issue logic allocates a destination register, marking it busy. Writeback clears the busy bit. Read ports return both the operand and its busy status, so the decode stage can stall without a separate hazard unit.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and allocs
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all registers, busy bits and busy_count
- write_en  input  1  writeback strobe
- write_reg  input  ADDR_WIDTH  writeback destination
- write_data  input  DATA_WIDTH  writeback value
- alloc_en  input  1  issue strobe: mark alloc_reg busy
- alloc_reg  input  ADDR_WIDTH  register to mark busy
- read_reg  input  NUM_READ*ADDR_WIDTH  packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  output  NUM_READ*DATA_WIDTH  packed read values, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- read_busy  output  NUM_READ  port i operand not yet available
- busy_count  output  ADDR_WIDTH+1  number of busy registers
- full  output  1  busy_count == depth (== depth-1 when ZERO_REG=1)

## Operation
- Storage: depth x DATA_WIDTH flops; busy: depth-bit vector; busy_count: registered counter.
- Write:
  - When write_en=1, mem[write_reg] <= write_data on the rising edge.
  - If ZERO_REG=1 and write_reg=0, the write is dropped.
- Read (combinational) per port i, with r = read_reg[i]:
  - If ZERO_REG=1 and r=0, the value is 0.
  - Else if BYPASS=1, write_en=1 and write_reg=r, the value is write_data.
  - Else the value is mem[r].
- Busy update, priority per register:
  - alloc to the register sets its busy bit.
  - Otherwise a write to the register clears it.
  - Otherwise the bit holds.
  - alloc_en=1 and write_en=1 to the same register: busy stays/becomes 1 (new producer wins), and the data is still written.
  - alloc or write to register 0 with ZERO_REG=1: no effect.
- read_busy[i] = busy[r], forced to 0 when:
  - ZERO_REG=1 and r=0, or
  - BYPASS=1 and the write to r this cycle is forwarded.
- busy_count changes by +1, -1 or 0 per cycle from the net set/clear on distinct registers:
  - Alloc to an already-busy register: no increment.
  - Write to a non-busy register: no decrement.
  - Alloc and write to different registers in the same cycle: both apply.
  - Never wraps: the counter cannot exceed depth by construction.
- full is combinational from busy_count. Allocating while full is legal and idempotent.

## Timing
- Reset assertion clears all state immediately (asynchronously):
  - read_data = 0, read_busy = 0, busy_count = 0, full = 0 while reset is low.
  - Release is synchronised by the flop behaviour only; the first update is on the first rising edge with reset high.
- Write latency:
  - 0 cycles to read_data when BYPASS=1.
  - 1 cycle (visible after the edge) when BYPASS=0.
- Alloc latency: read_busy rises the cycle after the alloc edge. There is no same-cycle alloc forwarding.
- Write clears busy: with BYPASS=1, read_busy for that register drops in the same cycle as the write; with BYPASS=0, it drops after the edge.
- Reset mid-operation discards any in-flight write or alloc on that edge.

## Structure
- Shared CPU package holds: DATA_WIDTH/ADDR_WIDTH defaults and the register-index type, reused by decode and writeback.
- One sub-module, rf_scoreboard: busy vector, set/clear priority, busy_count, full.
- The top level holds storage, read muxes and the bypass compare.

## Test plan
- Reset low with writes and allocs toggling -> all read_data 0, busy_count 0 throughout. Release, write r1=0xAAAAAAAA -> next cycle read port0 r1 = 0xAAAAAAAA.
- BYPASS=1: write r2=0xCCCCCCCC while port1 reads r2 in the same cycle -> read_data1 = 0xCCCCCCCC combinationally. BYPASS=0 build of the same test -> old value (0) that cycle, 0xCCCCCCCC the next.
- ZERO_REG=1: write r0=0xFFFFFFFF and alloc r0 -> r0 reads 0, read_busy 0, busy_count unchanged.
- Alloc r5 -> busy_count 1, read_busy 1 on a port reading r5. Write r5=0x12345678 -> same cycle read 0x12345678 with read_busy 0, busy_count 0 after the edge.
- Alloc r7 and write r7 in the same cycle -> r7 data updated, busy stays 1, busy_count +1. Alloc r3 with a write to busy r4 in the same cycle -> count unchanged.
- Allocate all 31 non-zero registers -> full=1, busy_count=31. Re-alloc r9 -> count stays 31. Pull reset low mid-sequence -> count 0, full 0 immediately.
